// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store initiator between the CPU memory stage and a word-organised
//   data memory. One request at a time over valid/ready. Sub-word stores are
//   done as read-modify-write because the memory always writes a full word.
//   Loads are lane-extracted and sign/zero-extended before a one-cycle
//   response pulse.
//
//   Optional feature: define MEM_ACCESS_EXC_EN to enable misalignment and
//   range faults (faulting requests skip memory and respond with resp_exc=1).
//
// Ports
//   clk, reset       clock, synchronous active-high reset
//   req_valid/ready  request handshake
//   req_op           000 LW 001 LH 010 LHU 011 LB 100 LBU 101 SW 110 SH 111 SB
//   req_addr         byte address
//   req_wdata        store data (SH [15:0], SB [7:0])
//   resp_valid       one-cycle response pulse
//   resp_rdata       extended load data (0 for stores), held between responses
//   resp_exc         request faulted, held between responses
//   mem_addr         word-aligned byte address to memory
//   mem_wdata        full word to write
//   mem_write        byte enables, commit at posedge
//   mem_rdata        combinational read of word at mem_addr
module mem_access_unit #(
  parameter int DM_WORDS = 3072
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_exc,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_write,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  localparam logic [31:0] DM_LIM = 32'(DM_WORDS);

`ifdef MEM_ACCESS_EXC_EN
  localparam logic EXC_EN = 1'b1;
`else
  // Checks fold away; resp_exc stays at its reset value of 0.
  localparam logic EXC_EN = 1'b0;
`endif

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic [1:0]      state, state_nxt;
  req_t            req_q;
  logic [3:0][7:0] word_q;
  logic [31:0]     rdata_q;
  logic            exc_q;

  // ---------------- fault detection on the incoming request ----------------
  logic mis_fault, rng_fault, fault;

  always_comb begin
    mis_fault = 1'b0;
    case (req_op)
      OP_LW, OP_SW:         mis_fault = |req_addr[1:0];
      OP_LH, OP_LHU, OP_SH: mis_fault = req_addr[0];
      default:              mis_fault = 1'b0;
    endcase
  end

  assign rng_fault = ({2'b00, req_addr[31:2]} >= DM_LIM);
  assign fault     = EXC_EN & (mis_fault | rng_fault);

  logic q_subword;
  assign q_subword = (req_q.op == OP_SH) || (req_q.op == OP_SB);

  // ---------------- FSM ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid)
              state_nxt = fault ? RESP : (req_op == OP_SW) ? WR : RD;
      RD:   state_nxt = q_subword ? WR : RESP;
      WR:   state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- load extraction ----------------
  logic [3:0][7:0] rd_lanes;
  logic [7:0]      ld_b;
  logic [15:0]     ld_h;
  logic [31:0]     ld_ext;

  assign rd_lanes = mem_rdata;
  assign ld_b     = rd_lanes[req_q.addr[1:0]];
  assign ld_h     = req_q.addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    ld_ext = '0;
    case (req_q.op)
      OP_LW:   ld_ext = mem_rdata;
      OP_LH:   ld_ext = {{16{ld_h[15]}}, ld_h};
      OP_LHU:  ld_ext = {16'h0, ld_h};
      OP_LB:   ld_ext = {{24{ld_b[7]}}, ld_b};
      OP_LBU:  ld_ext = {24'h0, ld_b};
      default: ld_ext = '0;
    endcase
  end

  // ---------------- store merge ----------------
  // Store data is replicated across lanes so each byte lane simply picks
  // either the new byte or the captured old byte according to its enable.
  logic [3:0]      be;
  logic [3:0][7:0] st_lanes, merged;

  always_comb begin
    be       = 4'b0000;
    st_lanes = req_q.wdata;
    case (req_q.op)
      OP_SW: be = 4'b1111;
      OP_SH: begin
        be       = 4'b0011 << {req_q.addr[1], 1'b0};
        st_lanes = {2{req_q.wdata[15:0]}};
      end
      OP_SB: begin
        be       = 4'b0001 << req_q.addr[1:0];
        st_lanes = {4{req_q.wdata[7:0]}};
      end
      default: be = 4'b0000;
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign merged[i] = be[i] ? st_lanes[i] : word_q[i];
  end

  // ---------------- outputs ----------------
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign mem_addr   = (state == RD || state == WR) ? {req_q.addr[31:2], 2'b00} : '0;
  assign mem_wdata  = (state == WR) ? merged : '0;
  // Gated by reset directly so a reset landing in WR never commits.
  assign mem_write  = (state == WR && !reset) ? be : 4'b0000;
  assign resp_rdata = rdata_q;
  assign resp_exc   = exc_q;

  // ---------------- state ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      req_q   <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      exc_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (req_valid) begin
          req_q <= {req_op, req_addr, req_wdata};
          if (fault) begin
            rdata_q <= '0;
            exc_q   <= 1'b1;
          end
        end
        RD: begin
          word_q <= mem_rdata;
          if (!q_subword) begin
            rdata_q <= ld_ext;
            exc_q   <= 1'b0;
          end
        end
        WR: begin
          rdata_q <= '0;
          exc_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small byte-enabled word memory.
module tb_mem_access_unit;

  localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                         LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

  logic        clk, reset;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_exc;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_write;

  mem_access_unit #(.DM_WORDS(3072)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_exc(resp_exc),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: 64 words, byte enables, plus a backdoor write port for setup.
  logic [31:0] mem [0:63];
  logic        bd_we;
  logic [5:0]  bd_idx;
  logic [31:0] bd_data;

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    else
      for (int b = 0; b < 4; b++)
        if (mem_write[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [5:0] idx, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = idx; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Results of the last run_req: cycle offsets relative to accept cycle T.
  int          r_lat, r_wcyc;
  logic [3:0]  r_be;
  logic [31:0] r_wd, r_rd;
  logic        r_exc;

  task automatic run_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] w);
    @(negedge clk);
    chk("ready_in_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = w;
    r_lat = 0; r_wcyc = 0; r_be = '0; r_wd = '0; r_rd = '0; r_exc = 1'b0;
    for (int k = 1; k <= 8 && r_lat == 0; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (mem_write != 4'b0 && r_wcyc == 0) begin
        r_wcyc = k; r_be = mem_write; r_wd = mem_wdata;
      end
      if (resp_valid) begin
        r_lat = k; r_rd = resp_rdata; r_exc = resp_exc;
      end
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
    bd_we = 1'b0; bd_idx = '0; bd_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_exc", {31'b0, resp_exc}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_write", {28'b0, mem_write}, 32'd0);
    reset = 1'b0;

    // SW then LW
    run_req(SW, 32'h10, 32'hDEADBEEF);
    chk("sw_wcyc", r_wcyc, 1);
    chk("sw_be", {28'b0, r_be}, 32'hF);
    chk("sw_wdata", r_wd, 32'hDEADBEEF);
    chk("sw_lat", r_lat, 2);
    chk("sw_rdata", r_rd, 32'd0);
    run_req(LW, 32'h10, 32'h0);
    chk("lw_lat", r_lat, 2);
    chk("lw_rdata", r_rd, 32'hDEADBEEF);
    @(negedge clk);
    chk("hold_valid", {31'b0, resp_valid}, 32'd0);
    chk("hold_rdata", resp_rdata, 32'hDEADBEEF);

    // SB read-modify-write
    poke(6'd4, 32'h11223344);
    run_req(SB, 32'h12, 32'h000000AA);
    chk("sb_wcyc", r_wcyc, 2);
    chk("sb_be", {28'b0, r_be}, 32'h4);
    chk("sb_wdata", r_wd, 32'h11AA3344);
    chk("sb_lat", r_lat, 3);
    chk("sb_mem", mem[4], 32'h11AA3344);

    // Load extension
    poke(6'd8, 32'h80F07F01);
    run_req(LB, 32'h20, 0);  chk("lb20", r_rd, 32'h00000001);
    run_req(LB, 32'h22, 0);  chk("lb22", r_rd, 32'hFFFFFFF0);
    run_req(LBU, 32'h23, 0); chk("lbu23", r_rd, 32'h00000080);
    run_req(LH, 32'h22, 0);  chk("lh22", r_rd, 32'hFFFF80F0);
    run_req(LHU, 32'h22, 0); chk("lhu22", r_rd, 32'h000080F0);
    run_req(LH, 32'h20, 0);  chk("lh20", r_rd, 32'h00007F01);
    chk("lh20_lat", r_lat, 2);

    // SH with req_valid held and a follow-on LW queued behind it
    poke(6'd0, 32'h0);
    @(negedge clk);
    req_valid = 1'b1; req_op = SH; req_addr = 32'h2; req_wdata = 32'h5566;
    @(negedge clk);
    chk("held_rd_ready", {31'b0, req_ready}, 32'd0);
    req_op = LW; req_addr = 32'h0; req_wdata = 32'h0;
    @(negedge clk);
    chk("held_wr_ready", {31'b0, req_ready}, 32'd0);
    chk("held_wr_be", {28'b0, mem_write}, 32'hC);
    chk("held_wr_wdata", mem_wdata, 32'h55660000);
    @(negedge clk);
    chk("held_resp_ready", {31'b0, req_ready}, 32'd0);
    chk("held_resp_valid", {31'b0, resp_valid}, 32'd1);
    @(negedge clk);
    chk("held_idle_ready", {31'b0, req_ready}, 32'd1);
    chk("held_idle_valid", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("held2_rd_ready", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    chk("held2_resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("held2_rdata", resp_rdata, 32'h55660000);

    // Reset during WR of an SB
    poke(6'd4, 32'h11223344);
    @(negedge clk);
    req_valid = 1'b1; req_op = SB; req_addr = 32'h11; req_wdata = 32'h77;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rstwr_pre_be", {28'b0, mem_write}, 32'h2);
    reset = 1'b1;
    #1;
    chk("rstwr_be", {28'b0, mem_write}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    chk("rstwr_ready", {31'b0, req_ready}, 32'd1);
    chk("rstwr_valid", {31'b0, resp_valid}, 32'd0);
    chk("rstwr_mem", mem[4], 32'h11223344);
    @(negedge clk);
    chk("rstwr_valid2", {31'b0, resp_valid}, 32'd0);

`ifdef MEM_ACCESS_EXC_EN
    run_req(LW, 32'h5, 0);
    chk("exc_mis_lat", r_lat, 1);
    chk("exc_mis_exc", {31'b0, r_exc}, 32'd1);
    chk("exc_mis_rdata", r_rd, 32'd0);
    chk("exc_mis_nowr", r_wcyc, 0);
    run_req(LW, 32'h3000, 0);
    chk("exc_rng_exc", {31'b0, r_exc}, 32'd1);
    chk("exc_rng_lat", r_lat, 1);
    run_req(SW, 32'h6, 32'h12345678);
    chk("exc_sw_nowr", r_wcyc, 0);
    chk("exc_sw_exc", {31'b0, r_exc}, 32'd1);
    run_req(LW, 32'h10, 0);
    chk("exc_clear", {31'b0, r_exc}, 32'd0);
`else
    poke(6'd1, 32'hCAFEF00D);
    run_req(LW, 32'h5, 0);
    chk("noexc_lat", r_lat, 2);
    chk("noexc_rdata", r_rd, 32'hCAFEF00D);
    chk("noexc_exc", {31'b0, r_exc}, 32'd0);
    run_req(LB, 32'h5, 0);
    chk("noexc_lb5", r_rd, 32'hFFFFFFF0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global guard so a stuck run still reports and ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator between the CPU's memory pipeline stage and the word-organised data memory. Accepts one load or store request at a time over a valid/ready handshake, produces word-aligned memory accesses, and performs read-modify-write for sub-word stores, since the data memory always writes a full 32-bit word. Load data is lane-extracted and sign- or zero-extended before the single-cycle response pulse.

## Interface
- DM_WORDS, 3072: data memory depth in 32-bit words; used for range checking.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_op  in  3  operation: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; SH uses [15:0], SB uses [7:0].
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  extended load data; 0 for stores.
- resp_exc  out  1  request faulted; valid with resp_valid.
- mem_addr  out  32  byte address to memory; bits [1:0] always 0.
- mem_wdata  out  32  full word to write.
- mem_write  out  4  byte enables; nonzero commits mem_wdata at posedge.
- mem_rdata  in  32  combinational read of word at mem_addr.

## Operation
- FSM states: IDLE, RD, WR, RESP. Reset -> IDLE.
- IDLE: req_ready=1. On req_valid, latch op, addr, wdata. Next state: loads -> RD; SW -> WR; SH/SB -> RD.
- RD: mem_addr = {addr[31:2],2'b00}, mem_write=0. Capture mem_rdata into word register. Loads -> RESP; SH/SB -> WR.
- WR: mem_addr aligned as above. mem_wdata = merged word: SW = wdata; SH replaces halfword lane addr[1]; SB replaces byte lane addr[1:0]; other lanes from captured word. mem_write: SW 1111, SH 0011<<(2*addr[1]), SB 0001<<addr[1:0]. -> RESP.
- RESP: resp_valid=1 for one cycle. -> IDLE.
- Little-endian lanes: byte 0 = bits [7:0]. LB/LH sign-extend, LBU/LHU zero-extend.
- req_ready=0 in RD, WR, and RESP. Requests presented there are not accepted and must be held by the source.
- Outside WR, mem_write=0. mem_write is forced to 0 whenever reset is high.
- resp_rdata and resp_exc hold their values between responses.
- Reset values: req_ready 1, resp_valid 0, resp_rdata 0, resp_exc 0, mem_addr 0, mem_wdata 0, mem_write 0.

## Timing
- Request accepted in cycle T, meaning req_valid & req_ready at the posedge ending T.
- Loads: RD in T+1, resp_valid in T+2.
- SW: WR in T+1, memory commits at the end of T+1, resp_valid in T+2.
- SH/SB: RD in T+1, WR in T+2, resp_valid in T+3.
- Next accept no earlier than T+3 for loads and SW, T+4 for SH/SB.
- Reset mid-operation: the next state is IDLE and the latched request is discarded. No write issues in the reset cycle, even if the FSM is in WR.
- A memory write committed before reset is not rolled back.

## Configuration
- MEM_ACCESS_EXC_EN defined:
  - Misalignment faults: LW/SW with addr[1:0]≠0; LH/LHU/SH with addr[0]≠0.
  - Range fault: addr[31:2] ≥ DM_WORDS.
  - Faulting request goes IDLE -> RESP, with resp_valid in T+1.
  - No memory access; resp_exc=1, resp_rdata=0.
- MEM_ACCESS_EXC_EN undefined:
  - resp_exc is tied to 0 and no checks are made.
  - Misaligned low address bits are ignored for alignment. Lane selection still uses addr[1] for halfwords and addr[1:0] for bytes.
  - Out-of-range addresses pass through unchanged.

## Test plan
- Reset, then SW addr 0x10 data 0xDEADBEEF -> mem_write 1111 in T+1, resp_valid T+2; then LW 0x10 -> resp_rdata 0xDEADBEEF.
- Word 0x10 = 0x11223344; SB addr 0x12 data 0xAA -> mem_write 0100, mem_wdata 0x11AA3344 in T+2, resp_valid T+3.
- Word 0x20 = 0x80F07F01: LB 0x20 -> 0x00000001; LB 0x22 -> 0xFFFFFFF0; LBU 0x23 -> 0x00000080; LH 0x22 -> 0xFFFF80F0; LHU 0x22 -> 0x000080F0.
- req_valid held high during SH to 0x2 with data 0x5566 (word 0x00000000) -> req_ready low in RD/WR/RESP; result 0x55660000; the held follow-on request is accepted only in IDLE.
- Reset asserted in WR of an SB -> mem_write 0 that cycle, memory unchanged, FSM in IDLE, resp_valid 0.
- With MEM_ACCESS_EXC_EN: LW 0x5 -> resp_valid T+1, resp_exc 1, mem_write never set; LW 0x3000 (word 3072) -> resp_exc 1; without macro, LW 0x5 -> returns word at 0x4, resp_exc 0.
